// File: rtl/viterbi_pkg.sv
// Shared Viterbi decoder types: path/branch metric widths, metric arrays and
// the balanced argmin tree used to pick the best state.
package viterbi_pkg;

  localparam int PM_W     = 12;
  localparam int N_STATES = 64;
  localparam int ST_W     = 6;
  localparam int BM_W     = 7;
  localparam int BM_MAX   = 98;

  typedef logic [PM_W-1:0] pm_t;
  typedef pm_t             pm_array [N_STATES];
  typedef logic [BM_W-1:0] bm_t;
  typedef bm_t             bm_array [N_STATES];
  typedef logic [ST_W-1:0] state_t;

  // Heap-ordered comparator tree: leaves at N_STATES..2*N_STATES-1, root at 1.
  // The left child always covers the lower indices, so the right child wins
  // only when strictly smaller and ties fall to the lowest state index.
  function automatic state_t argmin(input pm_array v);
    pm_t    node_v [1:2*N_STATES-1];
    state_t node_i [1:2*N_STATES-1];
    for (int j = 0; j < N_STATES; j++) begin
      node_v[N_STATES+j] = v[j];
      node_i[N_STATES+j] = state_t'(j);
    end
    for (int n = N_STATES - 1; n >= 1; n--) begin
      if (node_v[2*n+1] < node_v[2*n]) begin
        node_v[n] = node_v[2*n+1];
        node_i[n] = node_i[2*n+1];
      end else begin
        node_v[n] = node_v[2*n];
        node_i[n] = node_i[2*n];
      end
    end
    return node_i[1];
  endfunction

endpackage

// File: rtl/acs_unit_if.sv
// Trellis-step bus between the branch metric unit, the ACS stage and the
// traceback stage.
interface acs_unit_if;
  import viterbi_pkg::*;

  logic              valid_i;
  bm_array           bm0;
  bm_array           bm1;
  logic              valid_o;
  logic [N_STATES-1:0] dec_o;
  state_t            best_state_o;

  modport master (
    output valid_i, bm0, bm1,
    input  valid_o, dec_o, best_state_o
  );

  modport slave (
    input  valid_i, bm0, bm1,
    output valid_o, dec_o, best_state_o
  );
endinterface

// File: rtl/acs_butterfly.sv
// One radix-2 butterfly: destination states j and j+32 share predecessors
// {j[4:0],0} and {j[4:0],1}; purely combinational add-compare-select.
module acs_butterfly
  import viterbi_pkg::*;
(
  input  pm_t  pm_p0,
  input  pm_t  pm_p1,
  input  bm_t  bm0_lo,
  input  bm_t  bm1_lo,
  input  bm_t  bm0_hi,
  input  bm_t  bm1_hi,
  output pm_t  pm_lo,
  output pm_t  pm_hi,
  output logic dec_lo,
  output logic dec_hi
);

  pm_t c0_lo, c1_lo, c0_hi, c1_hi;

  // Sums stay at PM_W bits; normalisation upstream keeps them from wrapping.
  assign c0_lo = pm_p0 + pm_t'(bm0_lo);
  assign c1_lo = pm_p1 + pm_t'(bm1_lo);
  assign c0_hi = pm_p0 + pm_t'(bm0_hi);
  assign c1_hi = pm_p1 + pm_t'(bm1_hi);

  // A tie keeps the p0 survivor.
  assign dec_lo = (c1_lo < c0_lo);
  assign dec_hi = (c1_hi < c0_hi);

  assign pm_lo = dec_lo ? c1_lo : c0_lo;
  assign pm_hi = dec_hi ? c1_hi : c0_hi;

endmodule

// File: rtl/acs_unit.sv
// Add-compare-select stage of the K=7 rate-1/2 Viterbi decoder: one trellis
// step per cycle, 64 registered path metrics, survivor bits and best state.
module acs_unit
  import viterbi_pkg::*;
#(
  parameter int unsigned INIT_BIAS = 256
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush,
  acs_unit_if.slave        io
);

  pm_array             pm_q;
  pm_array             pm_cand;
  pm_array             pm_norm;
  logic [N_STATES-1:0] dec_cand;
  logic [N_STATES-1:0] dec_q;
  state_t              best_d;
  state_t              best_q;
  logic                valid_q;
  logic                all_msb;

  for (genvar i = 0; i < N_STATES / 2; i++) begin : g_bfly
    acs_butterfly u_bfly (
      .pm_p0  (pm_q[2*i]),
      .pm_p1  (pm_q[2*i+1]),
      .bm0_lo (io.bm0[i]),
      .bm1_lo (io.bm1[i]),
      .bm0_hi (io.bm0[i+N_STATES/2]),
      .bm1_hi (io.bm1[i+N_STATES/2]),
      .pm_lo  (pm_cand[i]),
      .pm_hi  (pm_cand[i+N_STATES/2]),
      .dec_lo (dec_cand[i]),
      .dec_hi (dec_cand[i+N_STATES/2])
    );
  end

  // Metric spread is bounded well below 2^(PM_W-1), so once every state has
  // its MSB set, dropping that bit preserves ordering and prevents wrap.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    all_msb = 1'b1;
    for (int j = 0; j < N_STATES; j++) begin
      all_msb = all_msb & pm_cand[j][PM_W-1];
    end
    for (int j = 0; j < N_STATES; j++) begin
      pm_norm[j]         = pm_cand[j];
      pm_norm[j][PM_W-1] = pm_cand[j][PM_W-1] & ~all_msb;
    end
  end

  assign best_d = argmin(pm_norm);

  // NOTE: the path-metric array is a register bank, not RAM, so it is reset
  // element by element; the encoder is known to start in state 0.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int j = 0; j < N_STATES; j++) begin
        pm_q[j] <= (j == 0) ? '0 : pm_t'(INIT_BIAS);
      end
      dec_q   <= '0;
      best_q  <= '0;
      valid_q <= 1'b0;
    end else if (flush) begin
      for (int j = 0; j < N_STATES; j++) begin
        pm_q[j] <= (j == 0) ? '0 : pm_t'(INIT_BIAS);
      end
      dec_q   <= '0;
      best_q  <= '0;
      valid_q <= 1'b0;
    end else if (io.valid_i) begin
      pm_q    <= pm_norm;
      dec_q   <= dec_cand;
      best_q  <= best_d;
      valid_q <= 1'b1;
    end else begin
      valid_q <= 1'b0;
    end
  end

  assign io.valid_o      = valid_q;
  assign io.dec_o        = dec_q;
  assign io.best_state_o = best_q;

endmodule

// File: tb/tb_acs_unit.sv
// Directed bench for acs_unit: hand-computed key values plus a behavioural
// trellis model that tracks all 64 metrics with unbounded integers.
module tb_acs_unit;
  import viterbi_pkg::*;

  logic clk_i = 1'b0;
  logic rst_ni;
  logic flush;

  acs_unit_if io ();

  acs_unit #(.INIT_BIAS(256)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .flush  (flush),
    .io     (io)
  );

  always #5 clk_i = ~clk_i;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          m_pm [N_STATES];
  logic [63:0] m_dec;
  int          m_best;
  bit          m_norm;
  bm_array     b0, b1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < N_STATES; j++) m_pm[j] = (j == 0) ? 0 : 256;
    m_dec  = '0;
    m_best = 0;
  endtask

  task automatic model_step();
    int nxt [N_STATES];
    int p0, c0, c1;
    m_norm = 1'b1;
    for (int j = 0; j < N_STATES; j++) begin
      p0 = 2 * (j % 32);
      c0 = m_pm[p0] + int'(b0[j]);
      c1 = m_pm[p0+1] + int'(b1[j]);
      m_dec[j] = (c1 < c0);
      nxt[j]   = (c1 < c0) ? c1 : c0;
      if (nxt[j] < 2048) m_norm = 1'b0;
    end
    m_best = 0;
    for (int j = 0; j < N_STATES; j++) begin
      m_pm[j] = m_norm ? nxt[j] - 2048 : nxt[j];
      if (m_pm[j] < m_pm[m_best]) m_best = j;
    end
  endtask

  task automatic check_all(input string tag, input logic exp_valid);
    check({tag, " valid_o"}, 64'(io.valid_o), 64'(exp_valid));
    check({tag, " dec_o"}, io.dec_o, m_dec);
    check({tag, " best"}, 64'(io.best_state_o), 64'(m_best));
    for (int j = 0; j < N_STATES; j++)
      check($sformatf("%s pm[%0d]", tag, j), 64'(dut.pm_q[j]), 64'(m_pm[j]));
  endtask

  task automatic fill(input int v0, input int v1);
    for (int j = 0; j < N_STATES; j++) begin
      b0[j] = bm_t'(v0);
      b1[j] = bm_t'(v1);
    end
  endtask

  task automatic do_reset();
    rst_ni     = 1'b0;
    flush      = 1'b0;
    io.valid_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    model_reset();
  endtask

  task automatic step();
    io.valid_i = 1'b1;
    io.bm0     = b0;
    io.bm1     = b1;
    @(posedge clk_i);
    #1;
    model_step();
  endtask

  task automatic idle();
    io.valid_i = 1'b0;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    fill(0, 0);
    io.bm0 = b0;
    io.bm1 = b1;

    // Reset state
    do_reset();
    check("rst pm0", 64'(dut.pm_q[0]), 64'd0);
    check("rst pm63", 64'(dut.pm_q[63]), 64'd256);
    check_all("rst", 1'b0);

    // bm0=0, bm1=98: only the state-0 survivors improve
    fill(0, 98);
    step();
    check("s1 pm32", 64'(dut.pm_q[32]), 64'd0);
    check("s1 pm1", 64'(dut.pm_q[1]), 64'd256);
    check("s1 dec", io.dec_o, 64'd0);
    check_all("s1", 1'b1);
    idle();
    check_all("s1 hold", 1'b0);

    // bm0=98, bm1=0: every state except 0/32 picks p1
    do_reset();
    fill(98, 0);
    step();
    check("s2 dec", io.dec_o, 64'hFFFF_FFFE_FFFF_FFFE);
    check("s2 best", 64'(io.best_state_o), 64'd0);
    check("s2 pm0", 64'(dut.pm_q[0]), 64'd98);
    check("s2 pm32", 64'(dut.pm_q[32]), 64'd98);
    check("s2 pm5", 64'(dut.pm_q[5]), 64'd256);
    check_all("s2", 1'b1);

    // Second step: states 16 and 48 tie for minimum, lowest index wins
    fill(98, 98);
    b0[16] = bm_t'(0);
    b0[48] = bm_t'(0);
    step();
    check("s3 best", 64'(io.best_state_o), 64'd16);
    check("s3 pm16", 64'(dut.pm_q[16]), 64'd98);
    check("s3 pm48", 64'(dut.pm_q[48]), 64'd98);
    check("s3 pm0", 64'(dut.pm_q[0]), 64'd196);
    check("s3 pm7", 64'(dut.pm_q[7]), 64'd354);
    check_all("s3", 1'b1);

    // Tie on equal predecessors selects p0 and adds exactly 5
    do_reset();
    fill(5, 5);
    step();
    check("tie pm1", 64'(dut.pm_q[1]), 64'd261);
    check("tie pm63", 64'(dut.pm_q[63]), 64'd261);
    check("tie pm0", 64'(dut.pm_q[0]), 64'd5);
    check("tie dec", io.dec_o, 64'd0);
    check_all("tie", 1'b1);

    // Asynchronous reset between edges, mid-stream
    step();
    #2;
    rst_ni = 1'b0;
    #1;
    model_reset();
    check_all("async rst", 1'b0);
    io.valid_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;

    // 100 back-to-back steps of 49/49: all metrics equal 49*k from step 6,
    // normalised at steps 42 (2058->10) and 84 (2068->20)
    fill(49, 49);
    for (int k = 0; k < 100; k++) begin
      step();
      check_all($sformatf("norm k%0d", k), 1'b1);
      if (m_norm) begin
        int mx = 0;
        for (int j = 0; j < N_STATES; j++)
          if (int'(dut.pm_q[j]) > mx) mx = int'(dut.pm_q[j]);
        check($sformatf("norm bound k%0d", k), 64'(mx < 2048), 64'd1);
      end
      if (k == 41) check("norm step42 pm63", 64'(dut.pm_q[63]), 64'd10);
      if (k == 83) check("norm step84 pm0", 64'(dut.pm_q[0]), 64'd20);
    end
    check("norm step100 pm0", 64'(dut.pm_q[0]), 64'd804);

    // Flush wins over valid_i mid-stream, then idle cycles hold reset values
    fill(98, 0);
    step();
    check("pre-flush dec", io.dec_o, 64'hFFFF_FFFF_FFFF_FFFF);
    flush = 1'b1;
    step();
    flush = 1'b0;
    model_reset();
    check_all("flush", 1'b0);
    for (int k = 0; k < 3; k++) begin
      idle();
      check_all($sformatf("post-flush idle%0d", k), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
